// File: rtl/tone_sequencer_if.sv
// Request and codec sample-write signals of the tone sequencer.
// The control side (keypad/FSM logic plus the codec's ready) uses the
// master modport; the sequencer uses the slave modport.
interface tone_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int PW    = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [PW-1:0] req_half_period;
    logic [DW-1:0] req_duration;
    logic          write_ready;
    logic          write;
    logic [23:0]   writedata_left;
    logic [23:0]   writedata_right;
    logic          busy;
    logic [CW-1:0] queue_count;

    modport master (
        output req_valid, req_half_period, req_duration, write_ready,
        input  req_ready, write, writedata_left, writedata_right, busy, queue_count
    );

    modport slave (
        input  req_valid, req_half_period, req_duration, write_ready,
        output req_ready, write, writedata_left, writedata_right, busy, queue_count
    );
endinterface

// File: rtl/tone_sequencer.sv
// Queues tone requests and plays them back-to-back as full-scale square
// waves into the codec sample-write port. Half-period and duration are
// counted in accepted codec samples (cycles with write_ready high).
module tone_sequencer #(
    parameter int DEPTH = 4,
    parameter int PW    = 16,
    parameter int DW    = 16
) (
    input  logic               clk,
    input  logic               reset,
    tone_sequencer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [PW-1:0] q_half [DEPTH];
    logic [DW-1:0] q_dur  [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;

    logic [PW-1:0] half;
    logic [PW-1:0] phase;
    logic [DW-1:0] remaining;
    logic          polarity;

    logic          ready;
    logic          push;
    logic          pop;
    logic          tick;

    assign ready     = (count < CW'(DEPTH));
    assign push      = bus.req_valid && ready;
    assign pop       = (state == LOAD);
    assign tick      = bus.write_ready;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Queue storage: written on push, no reset needed since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            q_half[wr_ptr] <= bus.req_half_period;
            q_dur[wr_ptr]  <= bus.req_duration;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
        end
    end

    // Tone counters: loaded from the queue head in LOAD, advanced on ticks in PLAY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half      <= '0;
            phase     <= '0;
            remaining <= '0;
            polarity  <= 1'b0;
        end else if (state == LOAD) begin
            half      <= (q_half[rd_ptr] == '0) ? PW'(1) : q_half[rd_ptr];
            phase     <= '0;
            remaining <= q_dur[rd_ptr];
            polarity  <= 1'b0;
        end else if (state == PLAY && tick) begin
            if (phase == half - PW'(1)) begin
                phase    <= '0;
                polarity <= ~polarity;
            end else begin
                phase <= phase + PW'(1);
            end
            remaining <= remaining - DW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and output decode; queue emptiness looks at the post-edge
    // occupancy so a same-cycle push keeps the sequencer going.
    always_comb begin
        state_nxt           = state;
        bus.write           = bus.write_ready;
        bus.writedata_left  = '0;
        bus.writedata_right = '0;
        bus.busy            = (state != IDLE) || (count != '0);
        bus.queue_count     = count;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = LOAD;
            end
            LOAD: begin
                if (q_dur[rd_ptr] == '0) state_nxt = (count_nxt != '0) ? LOAD : IDLE;
                else                     state_nxt = PLAY;
            end
            PLAY: begin
                bus.writedata_left  = polarity ? 24'h800000 : 24'h7FFFFF;
                bus.writedata_right = polarity ? 24'h800000 : 24'h7FFFFF;
                if (tick && remaining == DW'(1)) state_nxt = (count_nxt != '0) ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = ready;
endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenarios followed by a
// randomized run, all compared against a queue-based tone model.
module tb_tone_sequencer;
    localparam int DEPTH = 4;
    localparam int PW    = 16;
    localparam int DW    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    tone_sequencer_if #(.DEPTH(DEPTH), .PW(PW), .DW(DW)) bus ();

    tone_sequencer #(.DEPTH(DEPTH), .PW(PW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Model: pending requests, plus the tone being played as a sample index k.
    typedef struct {
        int half;
        int dur;
    } req_t;

    req_t mq[$];
    req_t cur;
    bit   playing = 1'b0;
    bit   loading = 1'b0;
    int   k       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data();
        if (!playing) return 32'h0;
        return (((k / cur.half) % 2) == 1) ? 32'h800000 : 32'h7FFFFF;
    endfunction

    task automatic model_clear();
        mq.delete();
        playing = 1'b0;
        loading = 1'b0;
        k       = 0;
    endtask

    task automatic check_outputs(input bit wr);
        chk("write",       32'(bus.write),           32'(wr));
        chk("left",        32'(bus.writedata_left),  exp_data());
        chk("right",       32'(bus.writedata_right), exp_data());
        chk("busy",        32'(bus.busy),            32'(playing || loading || mq.size() != 0));
        chk("req_ready",   32'(bus.req_ready),       32'(mq.size() < DEPTH));
        chk("queue_count", 32'(bus.queue_count),     32'(mq.size()));
    endtask

    task automatic model_clock(input bit v, input int hp, input int du, input bit wr);
        int   sz_before;
        bit   pushed;
        req_t r;
        sz_before = mq.size();
        pushed    = v && (sz_before < DEPTH);
        r         = '{0, 0};
        if (loading) r = mq.pop_front();
        if (pushed) mq.push_back('{hp, du});
        if (loading) begin
            if (r.dur == 0) begin
                loading = (mq.size() != 0);
            end else begin
                loading  = 1'b0;
                playing  = 1'b1;
                k        = 0;
                cur.half = (r.half == 0) ? 1 : r.half;
                cur.dur  = r.dur;
            end
        end else if (playing) begin
            if (wr) begin
                k++;
                if (k == cur.dur) begin
                    playing = 1'b0;
                    loading = (mq.size() != 0);
                end
            end
        end else begin
            loading = (sz_before != 0);
        end
    endtask

    task automatic step(input bit v, input int hp, input int du, input bit wr);
        bus.req_valid       = v;
        bus.req_half_period = PW'(hp);
        bus.req_duration    = DW'(du);
        bus.write_ready     = wr;
        #1;
        check_outputs(wr);
        @(posedge clk);
        model_clock(v, hp, du, wr);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid       = 1'b0;
        bus.req_half_period = '0;
        bus.req_duration    = '0;
        bus.write_ready     = 1'b1;
        model_clear();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy),           32'h0);
        chk("rst_ready", 32'(bus.req_ready),      32'h1);
        chk("rst_count", 32'(bus.queue_count),    32'h0);
        chk("rst_data",  32'(bus.writedata_left), 32'h0);
        chk("rst_write", 32'(bus.write),          32'h1);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) step(0, 0, 0, 1);

        // Single tone, continuous ticks
        step(1, 2, 8, 1);
        repeat (14) step(0, 0, 0, 1);

        // Same tone with write_ready alternating
        step(1, 2, 8, 1);
        for (int i = 0; i < 24; i++) step(0, 0, 0, (i % 2) == 0);
        repeat (4) step(0, 0, 0, 1);

        // Fill the queue with no ticks; extra push is dropped
        for (int i = 0; i < 6; i++) step(1, i + 1, i + 3, 0);
        #1;
        chk("full_count", 32'(bus.queue_count), 32'h4);
        chk("full_ready", 32'(bus.req_ready),   32'h0);
        repeat (60) step(0, 0, 0, 1);

        // half=0 alternates every sample; dur=0 is skipped
        step(1, 0, 3, 1);
        step(1, 5, 0, 1);
        repeat (10) step(0, 0, 0, 1);
        chk("skip_idle", 32'(bus.busy), 32'h0);

        // Reset during the third sample of a long tone with two queued
        step(1, 4, 100, 0);
        step(1, 3, 5, 0);
        step(1, 2, 5, 0);
        for (int i = 0; i < 20 && !(playing && k == 2); i++) step(0, 0, 0, 1);
        compared++;
        assert (playing && k == 2) else begin
            mismatched++;
            $error("FAIL reach_third_sample: observed k=%0d expected k=2", k);
        end
        bus.write_ready = 1'b1;
        #1;
        check_outputs(1);
        #1;
        reset = 1'b1;
        #1;
        model_clear();
        chk("abort_data",  32'(bus.writedata_left),  32'h0);
        chk("abort_right", 32'(bus.writedata_right), 32'h0);
        chk("abort_count", 32'(bus.queue_count),     32'h0);
        chk("abort_busy",  32'(bus.busy),            32'h0);
        chk("abort_ready", 32'(bus.req_ready),       32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) step(0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 6)), $urandom_range(0, 3) != 0);
        repeat (120) step(0, 0, 0, 1);
        chk("final_busy", 32'(bus.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
